// File: rtl/otter_intr_ctrl_if.sv
// ---------------------------------------------------------------------------
// otter_intr_ctrl_if
// Bundle of the OTTER interrupt controller's peripheral, CPU handshake and
// memory-mapped IO signals.
//   irq_in    : asynchronous peripheral interrupt lines (rising edge significant)
//   int_taken : one-cycle trap acknowledge from the CU_FSM interrupt state
//   IO_ADDR   : word offset 0 PENDING, 1 ENABLE, 2 CLAIM, 3 EOI
//   IO_RD     : read strobe, IO_WR : write strobe, IO_WDATA : write data
//   IO_RDATA  : registered read data
//   INTR      : interrupt request to the CPU
//   intr_id   : ID of the source currently requested or in service
// The master modport is the CPU/system side; the slave modport is the block.
// ---------------------------------------------------------------------------
interface otter_intr_ctrl_if #(
  parameter int NUM_SRC = 8
);
  logic [NUM_SRC-1:0] irq_in;
  logic               int_taken;
  logic [1:0]         IO_ADDR;
  logic               IO_RD;
  logic               IO_WR;
  logic [31:0]        IO_WDATA;
  logic [31:0]        IO_RDATA;
  logic               INTR;
  logic [3:0]         intr_id;

  modport master (
    output irq_in, int_taken, IO_ADDR, IO_RD, IO_WR, IO_WDATA,
    input  IO_RDATA, INTR, intr_id
  );

  modport slave (
    input  irq_in, int_taken, IO_ADDR, IO_RD, IO_WR, IO_WDATA,
    output IO_RDATA, INTR, intr_id
  );
endinterface

// File: rtl/otter_intr_ctrl.sv
// ---------------------------------------------------------------------------
// otter_intr_ctrl
// Edge-triggered, fixed-priority interrupt controller for the OTTER CPU.
// Each irq_in line is synchronized; a rising edge latches a PENDING bit.
// Enabled pending sources raise INTR with the lowest-index source ID; the CPU
// acknowledges with int_taken (the source moves into service and its PENDING
// bit is cleared) and finishes with a write to EOI. No nesting.
// Ports:
//   clk   : clock, all state on rising edge
//   RST_N : asynchronous active-low reset
//   bus   : otter_intr_ctrl_if.slave (interrupt lines, handshake, IO port)
// Register map (word offsets): 0 PENDING (W1C), 1 ENABLE (RW),
//   2 CLAIM (RO, {27'b0, valid, intr_id}), 3 EOI (WO, reads 0).
// ---------------------------------------------------------------------------
module otter_intr_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic              clk,
  input  logic              RST_N,
  otter_intr_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  localparam logic [1:0] A_PENDING = 2'd0;
  localparam logic [1:0] A_ENABLE  = 2'd1;
  localparam logic [1:0] A_CLAIM   = 2'd2;
  localparam logic [1:0] A_EOI     = 2'd3;

  logic [1:0]         state, state_next;
  logic [NUM_SRC-1:0] sync1, sync2, sync_prev;
  logic [2:0]         warm;
  logic               ready;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending, pending_next;
  logic [NUM_SRC-1:0] enable, enable_next;
  logic [NUM_SRC-1:0] pe, pe_next;
  logic [NUM_SRC-1:0] w1c_mask, claim_mask;
  logic [3:0]         pick_next;
  logic [3:0]         id_q, id_next;
  logic               intr_q;
  logic [31:0]        rdata_q, rdata_next;
  logic               wr_pending, wr_enable, wr_eoi, take;
  logic               unused_wdata;

  // Upper write-data bits beyond the source count are deliberately ignored.
  assign unused_wdata = ^bus.IO_WDATA[31:NUM_SRC];

  // Two-flop synchronizer plus previous-value register for edge detection.
  // The warm-up shift register holds off edge detection until both the
  // synchronizer and the history register contain post-reset samples, so a
  // line held high across reset release never looks like a new edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
      warm      <= '0;
    end else begin
      sync1     <= bus.irq_in;
      sync2     <= sync1;
      sync_prev <= sync2;
      warm      <= {warm[1:0], 1'b1};
    end
  end

  assign ready = warm[2];
  assign rise  = sync2 & ~sync_prev & {NUM_SRC{ready}};

  // Register decode
  assign wr_pending = bus.IO_WR && (bus.IO_ADDR == A_PENDING);
  assign wr_enable  = bus.IO_WR && (bus.IO_ADDR == A_ENABLE);
  assign wr_eoi     = bus.IO_WR && (bus.IO_ADDR == A_EOI);
  assign take       = (state == S_REQ) && bus.int_taken;

  assign w1c_mask   = wr_pending ? bus.IO_WDATA[NUM_SRC-1:0] : '0;

  // One-hot of the source being acknowledged; id_q always names the
  // lowest enabled pending source while in REQ.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    claim_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_mask[i] = take && (id_q == 4'(i));
    end
  end

  // A new edge wins over both a W1C write and the claim clear.
  assign pending_next = (pending & ~w1c_mask & ~claim_mask) | rise;
  assign enable_next  = wr_enable ? bus.IO_WDATA[NUM_SRC-1:0] : enable;
  assign pe           = pending & enable;
  assign pe_next      = pending_next & enable_next;

  // Lowest index has highest priority: scan downward, last hit wins.
  always_comb begin
    pick_next = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pe_next[i]) pick_next = 4'(i);
    end
  end

  // Entry to REQ looks at the registered PENDING&ENABLE (one cycle after the
  // PENDING bit appears); leaving REQ looks at the next-cycle value so INTR
  // drops on the same edge that removes the last request.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if ((pe != '0) && (pe_next != '0)) state_next = S_REQ;
      S_REQ:     if (bus.int_taken)                 state_next = S_SERVICE;
                 else if (pe_next == '0)            state_next = S_IDLE;
      S_SERVICE: if (wr_eoi)                        state_next = S_IDLE;
      default:                                      state_next = S_IDLE;
    endcase
  end

  // intr_id follows the winner while requesting, freezes in service.
  always_comb begin
    id_next = '0;
    case (state_next)
      S_REQ:     id_next = pick_next;
      S_SERVICE: id_next = id_q;
      default:   id_next = '0;
    endcase
  end

  // Read mux samples pre-write values, so a read and write to the same
  // offset in one cycle returns the old contents.
  always_comb begin
    rdata_next = rdata_q;
    if (bus.IO_RD) begin
      case (bus.IO_ADDR)
        A_PENDING: rdata_next = 32'(pending);
        A_ENABLE:  rdata_next = 32'(enable);
        A_CLAIM:   rdata_next = {27'b0, (state != S_IDLE), id_q};
        default:   rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      pending <= '0;
      enable  <= '0;
      id_q    <= '0;
      intr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      enable  <= enable_next;
      id_q    <= id_next;
      intr_q  <= (state_next == S_REQ);
      rdata_q <= rdata_next;
    end
  end

  assign bus.INTR     = intr_q;
  assign bus.intr_id  = id_q;
  assign bus.IO_RDATA = rdata_q;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_otter_intr_ctrl
// Directed self-checking bench for otter_intr_ctrl (NUM_SRC = 8).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. after the edge has settled.
// ---------------------------------------------------------------------------
module tb_otter_intr_ctrl;

  localparam int NUM_SRC = 8;

  logic clk;
  logic RST_N;
  int   checks;
  int   failures;

  otter_intr_ctrl_if #(.NUM_SRC(NUM_SRC)) bus ();

  otter_intr_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .clk   (clk),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus.IO_ADDR  = addr;
    bus.IO_WDATA = data;
    bus.IO_WR    = 1'b1;
    tick();
    bus.IO_WR    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] addr);
    bus.IO_ADDR = addr;
    bus.IO_RD   = 1'b1;
    tick();
    bus.IO_RD   = 1'b0;
  endtask

  task automatic take();
    bus.int_taken = 1'b1;
    tick();
    bus.int_taken = 1'b0;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    RST_N           = 1'b0;
    bus.irq_in      = '0;
    bus.int_taken   = 1'b0;
    bus.IO_ADDR     = 2'd0;
    bus.IO_RD       = 1'b0;
    bus.IO_WR       = 1'b0;
    bus.IO_WDATA    = '0;

    // Reset state
    #2;
    check("rst_intr",  32'(bus.INTR),    32'h0);
    check("rst_id",    32'(bus.intr_id), 32'h0);
    check("rst_rdata", bus.IO_RDATA,     32'h0);
    ticks(2);
    RST_N = 1'b1;
    ticks(4);
    rd(2'd0);
    check("rst_pending", bus.IO_RDATA, 32'h0);

    // Single source: PENDING after 3 edges, INTR after 4
    wr(2'd1, 32'h01);
    bus.irq_in[0] = 1'b1;
    ticks(3);
    check("s0_intr_e3", 32'(bus.INTR), 32'h0);
    rd(2'd0);
    bus.irq_in[0] = 1'b0;
    check("s0_pending_e3", bus.IO_RDATA,     32'h01);
    check("s0_intr_e4",    32'(bus.INTR),    32'h1);
    check("s0_id_e4",      32'(bus.intr_id), 32'h0);
    take();
    check("s0_taken_intr", 32'(bus.INTR), 32'h0);
    rd(2'd0);
    check("s0_taken_pending", bus.IO_RDATA, 32'h0);
    rd(2'd2);
    check("s0_claim_svc", bus.IO_RDATA, 32'h10);
    wr(2'd3, 32'h0);
    rd(2'd2);
    check("s0_claim_after_eoi", bus.IO_RDATA, 32'h00);

    // Two simultaneous edges: lowest index wins, the other follows after EOI
    wr(2'd1, 32'hFF);
    bus.irq_in = 8'h24;
    ticks(3);
    bus.irq_in = 8'h00;
    tick();
    check("pri_intr", 32'(bus.INTR),    32'h1);
    check("pri_id",   32'(bus.intr_id), 32'h2);
    take();
    check("pri_taken_intr", 32'(bus.INTR),    32'h0);
    check("pri_taken_id",   32'(bus.intr_id), 32'h2);
    rd(2'd0);
    check("pri_pending", bus.IO_RDATA, 32'h20);
    wr(2'd3, 32'h0);
    check("pri_eoi_intr", 32'(bus.INTR), 32'h0);
    tick();
    check("pri_next_intr", 32'(bus.INTR),    32'h1);
    check("pri_next_id",   32'(bus.intr_id), 32'h5);
    take();
    wr(2'd3, 32'h0);

    // Request withdrawn by disabling the source
    wr(2'd1, 32'h08);
    bus.irq_in[3] = 1'b1;
    ticks(3);
    bus.irq_in[3] = 1'b0;
    tick();
    check("dis_req_intr", 32'(bus.INTR),    32'h1);
    check("dis_req_id",   32'(bus.intr_id), 32'h3);
    wr(2'd1, 32'h00);
    check("dis_intr", 32'(bus.INTR), 32'h0);
    rd(2'd2);
    check("dis_claim_valid", 32'(bus.IO_RDATA[4]), 32'h0);
    rd(2'd0);
    check("dis_pending", bus.IO_RDATA, 32'h08);
    wr(2'd0, 32'h08);
    rd(2'd0);
    check("w1c_clear", bus.IO_RDATA, 32'h00);

    // W1C colliding with a new edge on the same bit: edge wins
    bus.irq_in[2] = 1'b1;
    ticks(2);
    wr(2'd0, 32'h04);
    bus.irq_in[2] = 1'b0;
    rd(2'd0);
    check("w1c_edge_wins", bus.IO_RDATA, 32'h04);
    wr(2'd0, 32'h04);
    rd(2'd0);
    check("w1c_no_edge", bus.IO_RDATA, 32'h00);

    // ENABLE write ignores upper bits
    wr(2'd1, 32'hABCD_0012);
    rd(2'd1);
    check("enable_low_bits", bus.IO_RDATA, 32'h12);

    // CLAIM in service, int_taken ignored in SERVICE
    wr(2'd1, 32'h40);
    bus.irq_in[6] = 1'b1;
    ticks(3);
    bus.irq_in[6] = 1'b0;
    tick();
    check("s6_intr", 32'(bus.INTR),    32'h1);
    check("s6_id",   32'(bus.intr_id), 32'h6);
    take();
    rd(2'd2);
    check("s6_claim", bus.IO_RDATA, 32'h16);
    take();
    check("s6_ign_intr", 32'(bus.INTR),    32'h0);
    check("s6_ign_id",   32'(bus.intr_id), 32'h6);
    rd(2'd2);
    check("s6_ign_claim", bus.IO_RDATA, 32'h16);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2);
    check("claim_wr_noop", bus.IO_RDATA, 32'h16);

    // Simultaneous read and write of ENABLE returns the old value
    bus.IO_ADDR  = 2'd1;
    bus.IO_WDATA = 32'hFF;
    bus.IO_RD    = 1'b1;
    bus.IO_WR    = 1'b1;
    tick();
    bus.IO_RD    = 1'b0;
    bus.IO_WR    = 1'b0;
    check("rdwr_old", bus.IO_RDATA, 32'h40);
    rd(2'd1);
    check("rdwr_new", bus.IO_RDATA, 32'hFF);
    rd(2'd3);
    check("eoi_read_zero", bus.IO_RDATA, 32'h0);

    // EOI write together with int_taken: SERVICE exits
    bus.IO_ADDR   = 2'd3;
    bus.IO_WDATA  = 32'h0;
    bus.IO_WR     = 1'b1;
    bus.int_taken = 1'b1;
    tick();
    bus.IO_WR     = 1'b0;
    bus.int_taken = 1'b0;
    rd(2'd2);
    check("eoi_take_valid", 32'(bus.IO_RDATA[4]), 32'h0);
    check("eoi_take_intr",  32'(bus.INTR),        32'h0);

    // Reset mid-SERVICE with irq_in[1] held high
    bus.irq_in[1] = 1'b1;
    ticks(3);
    tick();
    check("s1_intr", 32'(bus.INTR),    32'h1);
    check("s1_id",   32'(bus.intr_id), 32'h1);
    take();
    rd(2'd2);
    check("s1_claim", bus.IO_RDATA, 32'h11);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_intr",  32'(bus.INTR),    32'h0);
    check("arst_id",    32'(bus.intr_id), 32'h0);
    check("arst_rdata", bus.IO_RDATA,     32'h0);
    ticks(2);
    RST_N = 1'b1;
    ticks(6);
    rd(2'd0);
    check("hold_high_no_pending", bus.IO_RDATA, 32'h00);
    rd(2'd2);
    check("abort_claim", bus.IO_RDATA, 32'h00);
    bus.irq_in[1] = 1'b0;
    ticks(3);
    bus.irq_in[1] = 1'b1;
    ticks(3);
    rd(2'd0);
    check("new_edge_pending", bus.IO_RDATA, 32'h02);
    bus.irq_in[1] = 1'b0;
    check("new_edge_intr_masked", 32'(bus.INTR), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
